// File: rtl/definitions_pkg.sv
// Shared definitions for the UART receive controller slice.
// Latency: n/a (types, constants and a helper only).
// Backpressure: n/a.
// Contents: oversample rate, default FIFO depth / timeout, controller state enum,
//           divisor helper.
package definitions_pkg;

   localparam int OVERSAMPLE_RATE   = 16;
   localparam int RX_FIFO_DEPTH_DEF = 4;
   localparam int TIMEOUT_BITS_DEF  = 4;
   localparam int LEVEL_W           = 5;

   typedef enum logic [1:0] {
      ST_OFF    = 2'd0,
      ST_LISTEN = 2'd1,
      ST_ACTIVE = 2'd2
   } ctrl_state_t;

   // Terminal count of the tick counter; a divisor of 0 behaves like 1.
   function automatic logic [15:0] tick_last_count(input logic [15:0] div);
      return (div == 16'd0) ? 16'd0 : (div - 16'd1);
   endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Receiver-side and byte-stream signals between the controller and its neighbours.
// Latency: n/a (wires only).
// Backpressure: m_valid/m_ready stream; rx_enabled gates frame starts.
// master: controller view (drives rx_enabled, s_tick, m_valid, m_data).
// slave : receiver + consumer view (drives rx_busy, rx_done, rx_err, rx_data, m_ready).
interface uart_rx_ctrl_if;

   logic       rx_busy;
   logic       rx_done;
   logic       rx_err;
   logic [7:0] rx_data;
   logic       rx_enabled;
   logic       s_tick;
   logic       m_valid;
   logic [7:0] m_data;
   logic       m_ready;

   modport master (
      input  rx_busy, rx_done, rx_err, rx_data, m_ready,
      output rx_enabled, s_tick, m_valid, m_data
   );

   modport slave (
      output rx_busy, rx_done, rx_err, rx_data, m_ready,
      input  rx_enabled, s_tick, m_valid, m_data
   );

endinterface

// File: rtl/uart_rx_fifo.sv
// Synchronous first-word-fall-through byte FIFO with occupancy level.
// Latency: head valid the cycle after a push into an empty FIFO.
// Backpressure: push refused when full unless a pop happens in the same cycle.
// Ports: clk, rstN; push/push_data in; pop in; head_valid/head_data out;
//        full, level (0..DEPTH) out.
module uart_rx_fifo
   import definitions_pkg::*;
#(
   parameter int DEPTH = RX_FIFO_DEPTH_DEF
)
(
   input  logic               clk,
   input  logic               rstN,
   input  logic               push,
   input  logic [7:0]         push_data,
   input  logic               pop,
   output logic               head_valid,
   output logic [7:0]         head_data,
   output logic               full,
   output logic [LEVEL_W-1:0] level
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [7:0]         mem [DEPTH];
   logic [PW-1:0]      wr_ptr;
   logic [PW-1:0]      rd_ptr;
   logic [LEVEL_W-1:0] level_q;
   logic               do_push;
   logic               do_pop;

   assign full       = (level_q == LEVEL_W'(DEPTH));
   assign head_valid = (level_q != '0);
   assign do_pop     = pop && head_valid;
   // A pop in the same cycle frees the slot the push needs.
   assign do_push    = push && (!full || do_pop);
   // Head reads as zero while empty so reset and drained states look alike.
   assign head_data  = head_valid ? mem[rd_ptr] : 8'h00;
   assign level      = level_q;

   // Power-of-two depth: pointers wrap by natural overflow.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_q <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({do_push, do_pop})
            2'b10:   level_q <= level_q + LEVEL_W'(1);
            2'b01:   level_q <= level_q - LEVEL_W'(1);
            default: level_q <= level_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: enable FSM, oversample tick, byte FIFO, status, idle timeout.
// Latency: byte visible on m_valid one cycle after rx_done; rx_enabled lags state by 1.
// Backpressure: full FIFO drops rx_enabled; a byte arriving while full sets overrun.
// Ports: clk, rstN; enable, baud_div, clr_status in; bus (master: receiver + stream);
//        overrun, err_count, idle_timeout, level out.
module uart_rx_ctrl
   import definitions_pkg::*;
#(
   parameter int RX_FIFO_DEPTH = RX_FIFO_DEPTH_DEF,
   parameter int TIMEOUT_BITS  = TIMEOUT_BITS_DEF
)
(
   input  logic               clk,
   input  logic               rstN,
   input  logic               enable,
   input  logic [15:0]        baud_div,
   input  logic               clr_status,
   uart_rx_ctrl_if.master     bus,
   output logic               overrun,
   output logic [7:0]         err_count,
   output logic               idle_timeout,
   output logic [LEVEL_W-1:0] level
);

   localparam int IDLE_LIMIT = TIMEOUT_BITS * OVERSAMPLE_RATE;
   localparam int IW         = $clog2(IDLE_LIMIT + 1);

   ctrl_state_t        state;
   logic               rx_en_q;
   logic [15:0]        tick_cnt;
   logic [15:0]        tick_last;
   logic               running;
   logic               tick;
   logic               tick_wrap;
   logic               fifo_valid;
   logic               fifo_full;
   logic [7:0]         fifo_head;
   logic [LEVEL_W-1:0] fifo_level;
   logic               pop;
   logic               drop;
   logic [IW-1:0]      idle_cnt;
   logic               idle_clr;
   logic               idle_inc;

   // ---------------------------------------------------------------- tick
   // The live divisor is compared every cycle, so a new value is picked up
   // at the next wrap; a count already past a smaller divisor wraps at once.
   assign tick_last = tick_last_count(baud_div);
   assign running   = (state != ST_OFF);
   assign tick      = running && (tick_cnt == tick_last);
   assign tick_wrap = (tick_cnt >= tick_last);

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         tick_cnt <= '0;
      end else if (!running || tick_wrap) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + 16'd1;
      end
   end

   // ----------------------------------------------------------------- FSM
   // Dropping enable mid-frame is honoured only at rx_done so the frame in
   // flight keeps its ticks.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state   <= ST_OFF;
         rx_en_q <= 1'b0;
      end else begin
         rx_en_q <= (state == ST_LISTEN) && (fifo_level < LEVEL_W'(RX_FIFO_DEPTH));
         case (state)
            ST_OFF: begin
               if (enable) state <= ST_LISTEN;
            end
            ST_LISTEN: begin
               if (!enable)          state <= ST_OFF;
               else if (bus.rx_busy) state <= ST_ACTIVE;
            end
            ST_ACTIVE: begin
               if (bus.rx_done) state <= enable ? ST_LISTEN : ST_OFF;
            end
            default: state <= ST_OFF;
         endcase
      end
   end

   // ---------------------------------------------------------------- FIFO
   assign pop  = bus.m_ready && fifo_valid;
   assign drop = bus.rx_done && fifo_full && !pop;

   uart_rx_fifo #(
      .DEPTH (RX_FIFO_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rstN       (rstN),
      .push       (bus.rx_done),
      .push_data  (bus.rx_data),
      .pop        (bus.m_ready),
      .head_valid (fifo_valid),
      .head_data  (fifo_head),
      .full       (fifo_full),
      .level      (fifo_level)
   );

   // -------------------------------------------------------------- status
   // A new event in the same cycle as clr_status wins over the clear.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         overrun   <= 1'b0;
         err_count <= 8'd0;
      end else begin
         if (drop)            overrun <= 1'b1;
         else if (clr_status) overrun <= 1'b0;

         if (bus.rx_err) begin
            if (clr_status)              err_count <= 8'd1;
            else if (err_count != 8'hFF) err_count <= err_count + 8'd1;
         end else if (clr_status) begin
            err_count <= 8'd0;
         end
      end
   end

   // -------------------------------------------------------- idle timeout
   // Counter parks at the limit so the pulse fires once per idle stretch.
   assign idle_clr = (state != ST_LISTEN) || bus.rx_done || pop;
   assign idle_inc = (state == ST_LISTEN) && (fifo_level != '0) && tick &&
                     (idle_cnt != IW'(IDLE_LIMIT));

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         idle_cnt     <= '0;
         idle_timeout <= 1'b0;
      end else begin
         idle_timeout <= !idle_clr && idle_inc && (idle_cnt == IW'(IDLE_LIMIT - 1));
         if (idle_clr)      idle_cnt <= '0;
         else if (idle_inc) idle_cnt <= idle_cnt + IW'(1);
      end
   end

   // ------------------------------------------------------------- outputs
   assign bus.rx_enabled = rx_en_q;
   assign bus.s_tick     = tick;
   assign bus.m_valid    = fifo_valid;
   assign bus.m_data     = fifo_head;
   assign level          = fifo_level;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: table-driven tick and FIFO vectors,
// hand-written sequences for frames, errors, idle timeout and reset.
module tb_uart_rx_ctrl;

   localparam int DEPTH = 4;

   logic        clk;
   logic        rstN;
   logic        enable;
   logic [15:0] baud_div;
   logic        clr_status;
   logic        overrun;
   logic [7:0]  err_count;
   logic        idle_timeout;
   logic [4:0]  level;

   uart_rx_ctrl_if bus ();

   uart_rx_ctrl #(
      .RX_FIFO_DEPTH (DEPTH),
      .TIMEOUT_BITS  (4)
   ) dut (
      .clk          (clk),
      .rstN         (rstN),
      .enable       (enable),
      .baud_div     (baud_div),
      .clr_status   (clr_status),
      .bus          (bus),
      .overrun      (overrun),
      .err_count    (err_count),
      .idle_timeout (idle_timeout),
      .level        (level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   logic [7:0] sb[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One clock: drive inputs, run scoreboard on the visible head, clock, release pulses.
   task automatic cyc(input logic done, input logic [7:0] d, input logic rdy,
                      input logic err, input logic clr, input logic busy);
      bus.rx_done  = done;
      bus.rx_data  = d;
      bus.m_ready  = rdy;
      bus.rx_err   = err;
      clr_status   = clr;
      bus.rx_busy  = busy;
      if (rdy && sb.size() > 0) begin
         chk("pop_valid", {31'd0, bus.m_valid}, 32'd1);
         chk("pop_data", {24'd0, bus.m_data}, {24'd0, sb[0]});
         void'(sb.pop_front());
      end
      if (done && sb.size() < DEPTH) sb.push_back(d);
      @(posedge clk);
      #1;
      bus.rx_done = 1'b0;
      bus.rx_data = 8'h00;
      bus.m_ready = 1'b0;
      bus.rx_err  = 1'b0;
      clr_status  = 1'b0;
      bus.rx_busy = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_s_tick"},     {31'd0, bus.s_tick},     32'd0);
      chk({tag, "_rx_enabled"}, {31'd0, bus.rx_enabled}, 32'd0);
      chk({tag, "_m_valid"},    {31'd0, bus.m_valid},    32'd0);
      chk({tag, "_m_data"},     {24'd0, bus.m_data},     32'd0);
      chk({tag, "_overrun"},    {31'd0, overrun},        32'd0);
      chk({tag, "_idle_to"},    {31'd0, idle_timeout},   32'd0);
      chk({tag, "_err_count"},  {24'd0, err_count},      32'd0);
      chk({tag, "_level"},      {27'd0, level},          32'd0);
   endtask

   typedef struct {
      logic        en;
      logic [15:0] div;
      int          exp_ticks;   // ticks seen in 24 cycles of LISTEN
   } tick_vec_t;

   typedef struct {
      logic       done;
      logic [7:0] d;
      logic       rdy;
      logic       clr;
      logic [4:0] exp_level;
      logic       exp_valid;
      logic       exp_ovr;
      logic       exp_en;
   } fifo_vec_t;

   tick_vec_t tv[7];
   fifo_vec_t fv[15];

   initial begin
      int ticks;
      int pulses;
      int pos;

      tv[0] = '{1'b1, 16'd4, 6};
      tv[1] = '{1'b1, 16'd0, 24};
      tv[2] = '{1'b0, 16'd4, 0};
      tv[3] = '{1'b1, 16'd1, 24};
      tv[4] = '{1'b1, 16'd3, 8};
      tv[5] = '{1'b1, 16'd6, 4};
      tv[6] = '{1'b1, 16'd2, 12};

      //          done  data   rdy   clr   lvl    vld   ovr   en
      fv[0]  = '{1'b1, 8'h01, 1'b0, 1'b0, 5'd1, 1'b1, 1'b0, 1'b1};
      fv[1]  = '{1'b1, 8'h02, 1'b0, 1'b0, 5'd2, 1'b1, 1'b0, 1'b1};
      fv[2]  = '{1'b1, 8'h03, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b1};
      fv[3]  = '{1'b1, 8'h04, 1'b0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b1};
      fv[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0};
      fv[5]  = '{1'b1, 8'h05, 1'b0, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0};
      fv[6]  = '{1'b0, 8'h00, 1'b0, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0};
      fv[7]  = '{1'b1, 8'h06, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0};
      fv[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0};
      fv[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd2, 1'b1, 1'b0, 1'b1};
      fv[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd1, 1'b1, 1'b0, 1'b1};
      fv[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1};
      fv[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1};
      fv[13] = '{1'b1, 8'hA5, 1'b1, 1'b0, 5'd1, 1'b1, 1'b0, 1'b1};
      fv[14] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1};

      // ---------------------------------------------------------- reset
      rstN        = 1'b0;
      enable      = 1'b0;
      baud_div    = 16'd4;
      clr_status  = 1'b0;
      bus.rx_busy = 1'b0;
      bus.rx_done = 1'b0;
      bus.rx_err  = 1'b0;
      bus.rx_data = 8'h00;
      bus.m_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_reset_outputs("rst");
      rstN = 1'b1;
      idle(2);

      // ------------------------------------------------- tick generation
      foreach (tv[i]) begin
         enable = 1'b0;
         idle(2);
         baud_div = tv[i].div;
         enable   = tv[i].en;
         idle(1);
         ticks = 0;
         for (int k = 0; k < 24; k++) begin
            if (bus.s_tick) ticks++;
            idle(1);
         end
         chk($sformatf("ticks_v%0d", i), ticks, tv[i].exp_ticks);
      end

      // --------------------------------------------------- single frame
      baud_div = 16'd4;
      idle(2);
      chk("en_listen", {31'd0, bus.rx_enabled}, 32'd1);
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      idle(1);
      chk("en_active", {31'd0, bus.rx_enabled}, 32'd0);
      cyc(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("frame_valid", {31'd0, bus.m_valid}, 32'd1);
      chk("frame_data", {24'd0, bus.m_data}, 32'hA5);
      chk("frame_level", {27'd0, level}, 32'd1);
      cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("frame_level_pop", {27'd0, level}, 32'd0);
      idle(2);

      // --------------------------------------- FIFO fill/overrun/drain
      foreach (fv[i]) begin
         cyc(fv[i].done, fv[i].d, fv[i].rdy, 1'b0, fv[i].clr, 1'b0);
         chk($sformatf("level_r%0d", i),  {27'd0, level},          {27'd0, fv[i].exp_level});
         chk($sformatf("valid_r%0d", i),  {31'd0, bus.m_valid},    {31'd0, fv[i].exp_valid});
         chk($sformatf("ovr_r%0d", i),    {31'd0, overrun},        {31'd0, fv[i].exp_ovr});
         chk($sformatf("rxen_r%0d", i),   {31'd0, bus.rx_enabled}, {31'd0, fv[i].exp_en});
      end

      // -------------------------- enable dropped during an active frame
      baud_div = 16'd2;
      idle(2);
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      enable = 1'b0;
      ticks = 0;
      for (int k = 0; k < 8; k++) begin
         if (bus.s_tick) ticks++;
         idle(1);
      end
      chk("ticks_active_disabled", ticks, 4);
      cyc(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
      ticks = 0;
      for (int k = 0; k < 8; k++) begin
         if (bus.s_tick) ticks++;
         idle(1);
      end
      chk("ticks_after_off", ticks, 0);
      chk("en_off", {31'd0, bus.rx_enabled}, 32'd0);
      enable = 1'b1;
      idle(2);
      cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("off_byte_level", {27'd0, level}, 32'd0);

      // ---------------------------------------------------- error count
      for (int k = 0; k < 300; k++) cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("err_sat", {24'd0, err_count}, 32'd255);
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("err_clr", {24'd0, err_count}, 32'd0);
      cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("err_two", {24'd0, err_count}, 32'd2);
      cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
      chk("err_clr_and_inc", {24'd0, err_count}, 32'd1);

      // --------------------------------------------------- idle timeout
      baud_div = 16'd1;
      idle(2);
      cyc(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
      pulses = 0;
      pos    = -1;
      for (int k = 1; k <= 100; k++) begin
         idle(1);
         if (idle_timeout) begin
            pulses++;
            if (pos < 0) pos = k;
         end
      end
      chk("idle_pulses", pulses, 1);
      chk("idle_position", pos, 64);
      cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("idle_drain_level", {27'd0, level}, 32'd0);

      // ----------------------------------------------- reset mid-frame
      cyc(1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("pre_rst_level", {27'd0, level}, 32'd1);
      #2;
      rstN = 1'b0;
      #1;
      chk_reset_outputs("midrst");
      sb.delete();
      @(posedge clk);
      #1;
      chk_reset_outputs("midrst_edge");
      rstN = 1'b1;
      idle(3);
      chk("post_rst_level", {27'd0, level}, 32'd0);
      chk("post_rst_valid", {31'd0, bus.m_valid}, 32'd0);
      chk("post_rst_overrun", {31'd0, overrun}, 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 Parameter RX_FIFO_DEPTH, default 4, receive FIFO entries (power of two, 2..16).
REQ-002 Parameter TIMEOUT_BITS, default 4, idle bit-periods before timeout pulse.
REQ-003 clk  input  1  sole clock.
REQ-004 rstN  input  1  reset, asynchronous, active-low.
REQ-005 enable  input  1  software receive enable.
REQ-006 baud_div  input  16  clk cycles per s_tick; value 0 treated as 1.
REQ-007 rx_busy  input  1  receiver busy, high for at least 1 cycle at frame start.
REQ-008 rx_done  input  1  receiver end-of-frame pulse, 1 cycle.
REQ-009 rx_err  input  1  receiver frame-error pulse, 1 cycle.
REQ-010 rx_data  input  8  receiver byte, valid with rx_done.
REQ-011 rx_enabled  output  1  start permission to receiver.
REQ-012 s_tick  output  1  oversample tick to receiver, 1-cycle pulse.
REQ-013 m_valid  output  1  FIFO head valid.
REQ-014 m_data  output  8  FIFO head byte.
REQ-015 m_ready  input  1  consumer accepts head.
REQ-016 overrun  output  1  sticky: byte dropped, FIFO full.
REQ-017 err_count  output  8  saturating frame-error count.
REQ-018 clr_status  input  1  pulse; clears overrun and err_count.
REQ-019 idle_timeout  output  1  1-cycle pulse, line idle with data pending.
REQ-020 level  output  5  FIFO occupancy, 0..RX_FIFO_DEPTH.

Function
REQ-021 FSM states OFF, LISTEN, ACTIVE; reset state OFF.
REQ-022 OFF->LISTEN when enable=1; LISTEN->OFF when enable=0; LISTEN->ACTIVE on rx_busy=1; ACTIVE->LISTEN on rx_done (enable=1) or ACTIVE->OFF on rx_done (enable=0).
REQ-023 enable deassert in ACTIVE: frame completes and s_tick continues until rx_done.
REQ-024 Tick counter runs in LISTEN/ACTIVE only, counts 0..max(baud_div,1)-1, s_tick=1 in the cycle count equals max-1; counter cleared in OFF.
REQ-025 baud_div change takes effect at next counter wrap; count at or above the new maximum wraps to 0.
REQ-026 rx_enabled = (state==LISTEN) and level<RX_FIFO_DEPTH, registered.
REQ-027 rx_done pushes rx_data; push accepted if not full or pop in same cycle.
REQ-028 Push when full without pop: byte dropped, overrun set next cycle.
REQ-029 Pop when m_valid=1 and m_ready=1; m_data is the head, first-word-fall-through, valid the cycle after push into empty FIFO.
REQ-030 Simultaneous push and pop: level unchanged, order preserved.
REQ-031 Read/write pointers wrap modulo RX_FIFO_DEPTH.
REQ-032 rx_err increments err_count, saturating at 255.
REQ-033 clr_status with simultaneous overrun set or rx_err: set/increment wins; err_count becomes 1.
REQ-034 Idle counter counts s_tick in LISTEN while level>0; cleared on push, pop, or leaving LISTEN.
REQ-035 idle_timeout pulses once when idle count reaches TIMEOUT_BITS*OVERSAMPLE_RATE; no re-pulse until counter cleared.

Reset
REQ-036 rstN low: state OFF, counters 0, FIFO empty, level 0.
REQ-037 rstN low: s_tick, rx_enabled, m_valid, overrun, idle_timeout 0; err_count 0; m_data 0x00.
REQ-038 Reset mid-frame discards frame and FIFO contents with no output pulse.

Structure
REQ-039 definitions_pkg holds OVERSAMPLE_RATE (16), ctrl state enum, RX_FIFO_DEPTH and TIMEOUT_BITS defaults.
REQ-040 Sub-module uart_rx_fifo (synchronous FIFO with level) instantiated once.

Verification
REQ-041 baud_div=4, enable=1 -> s_tick every 4th clk; baud_div=0 -> s_tick every clk; enable=0 -> no s_tick.
REQ-042 Frame 0xA5 via rx_busy then rx_done -> m_valid=1 with m_data=0xA5, level=1; m_ready pop -> level=0.
REQ-043 Push 4 bytes 0x01..0x04 with m_ready=0 -> rx_enabled=0; 5th rx_done -> overrun=1, pops return 0x01..0x04.
REQ-044 Full FIFO, rx_done with m_ready=1 same cycle -> level stays 4, no overrun, new byte last.
REQ-045 300 rx_err pulses -> err_count=255; clr_status -> 0; clr_status with rx_err same cycle -> 1.
REQ-046 1 byte held, baud_div=1, no activity -> idle_timeout pulses once after 64 s_ticks; rstN low mid-frame -> all outputs at reset values.
